ntt_cmd_scheduler: RTL and testbench

- Command scheduler sitting in front of the NTT processor core.
- Queues host operation requests (NTT, INTT, MULT, ADDSUB with operand and result offsets) in a small FIFO and issues them to the core one at a time.
- For each operation it drives a one-cycle start pulse, holds the core configuration stable for the core's fixed run length, and reports completion with a tag and an observed write count.

---
 rtl/ntt_cmd_scheduler.sv | 143 ++++++++++++++
 tb/tb_ntt_cmd_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_cmd_scheduler.sv
// Command scheduler for the NTT core: queues host requests in a FIFO and issues them one at a
// time, pulsing core_start, holding the configuration for the fixed run length, then reporting done.
module ntt_cmd_scheduler #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned LAT_NTT    = 234,
    parameter int unsigned LAT_MULT   = 146,
    parameter int unsigned LAT_ADDSUB = 70
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_mode,
    input  logic                       cmd_add_or_sub,
    input  logic [7:0]                 cmd_off_a,
    input  logic [7:0]                 cmd_off_b,
    input  logic [7:0]                 cmd_off_w,
    input  logic [3:0]                 cmd_tag,
    input  logic                       flush,
    output logic                       core_start,
    output logic [1:0]                 core_mode,
    output logic                       core_add_or_sub,
    output logic [7:0]                 core_r_start_offset_A,
    output logic [7:0]                 core_r_start_offset_B,
    output logic [7:0]                 core_w_data_addr_offset,
    input  logic                       core_w_data_en,
    output logic                       done,
    output logic [3:0]                 done_tag,
    output logic [7:0]                 done_wr_count,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 4 + 2 + 1 + 8 + 8 + 8;

    typedef enum logic [1:0] {StIdle, StIssue, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            full, empty, push, pop;
    logic [EW-1:0]   entry, head;

    logic [1:0]      mode_q;
    logic            aos_q;
    logic [7:0]      off_a_q, off_b_q, off_w_q;
    logic [3:0]      tag_q;
    logic [7:0]      run_cnt_q, wr_cnt_q;
    logic [7:0]      lat_m1;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign cmd_ready = ~full & ~flush;
    assign push      = cmd_valid & cmd_ready;
    // flush wins over a pending pop so nothing leaves the queue on a flush edge
    assign pop       = (state_q == StIdle) & ~empty & ~flush;
    assign entry     = {cmd_tag, cmd_mode, cmd_add_or_sub, cmd_off_a, cmd_off_b, cmd_off_w};
    assign head      = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    always_comb begin
        lat_m1 = 8'(LAT_NTT - 1);
        unique case (mode_q)
            2'd0, 2'd1: lat_m1 = 8'(LAT_NTT - 1);
            2'd2:       lat_m1 = 8'(LAT_MULT - 1);
            2'd3:       lat_m1 = 8'(LAT_ADDSUB - 1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (pop) state_d = StIssue;
            StIssue: state_d = StRun;
            StRun:   if (run_cnt_q == lat_m1) state_d = StDone;
            StDone:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            mode_q    <= '0;
            aos_q     <= 1'b0;
            off_a_q   <= '0;
            off_b_q   <= '0;
            off_w_q   <= '0;
            tag_q     <= '0;
            run_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                {tag_q, mode_q, aos_q, off_a_q, off_b_q, off_w_q} <= head;
            end
            if (state_q == StIssue) begin
                run_cnt_q <= '0;
                wr_cnt_q  <= '0;
            end else if (state_q == StRun) begin
                run_cnt_q <= run_cnt_q + 1'b1;
                if (core_w_data_en && wr_cnt_q != 8'hff) wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end
    end

    assign core_start              = (state_q == StIssue);
    assign busy                    = (state_q != StIdle);
    assign done                    = (state_q == StDone);
    assign done_tag                = done ? tag_q : '0;
    assign done_wr_count           = done ? wr_cnt_q : '0;
    assign core_mode               = mode_q;
    assign core_add_or_sub         = aos_q;
    assign core_r_start_offset_A   = off_a_q;
    assign core_r_start_offset_B   = off_b_q;
    assign core_w_data_addr_offset = off_w_q;
    assign fifo_level              = level_q;

endmodule

// File: tb/tb_ntt_cmd_scheduler.sv
// Scoreboard bench for ntt_cmd_scheduler: stimulus queues expected issues/completions,
// a negedge monitor pops and compares them as core_start / done appear.
module tb_ntt_cmd_scheduler;

    localparam int LAT_NTT    = 234;
    localparam int LAT_MULT   = 146;
    localparam int LAT_ADDSUB = 70;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid, cmd_ready, cmd_add_or_sub, flush;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_off_a, cmd_off_b, cmd_off_w;
    logic [3:0] cmd_tag;
    logic       core_start, core_add_or_sub, core_w_data_en, done, busy;
    logic [1:0] core_mode;
    logic [7:0] core_r_start_offset_A, core_r_start_offset_B, core_w_data_addr_offset;
    logic [3:0] done_tag;
    logic [7:0] done_wr_count;
    logic [2:0] fifo_level;

    ntt_cmd_scheduler dut (
        .clk                     (clk),
        .rst                     (rst),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_mode                (cmd_mode),
        .cmd_add_or_sub          (cmd_add_or_sub),
        .cmd_off_a               (cmd_off_a),
        .cmd_off_b               (cmd_off_b),
        .cmd_off_w               (cmd_off_w),
        .cmd_tag                 (cmd_tag),
        .flush                   (flush),
        .core_start              (core_start),
        .core_mode               (core_mode),
        .core_add_or_sub         (core_add_or_sub),
        .core_r_start_offset_A   (core_r_start_offset_A),
        .core_r_start_offset_B   (core_r_start_offset_B),
        .core_w_data_addr_offset (core_w_data_addr_offset),
        .core_w_data_en          (core_w_data_en),
        .done                    (done),
        .done_tag                (done_tag),
        .done_wr_count           (done_wr_count),
        .busy                    (busy),
        .fifo_level              (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] tag;
        logic [7:0] wr;
        int         lat;
    } done_t;

    logic [26:0] sq[$];
    done_t       dq[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input logic [1:0] m);
        case (m)
            2'd2:    return LAT_MULT;
            2'd3:    return LAT_ADDSUB;
            default: return LAT_NTT;
        endcase
    endfunction

    // Core stub: write strobe high for wr_pulses cycles starting wr_first cycles after ISSUE.
    int stub_cnt = 0;
    bit stub_on = 1'b0;
    int wr_first = 1;
    int wr_pulses = 0;
    always @(negedge clk) begin
        if (core_start) begin
            stub_cnt = 0;
            stub_on  = 1'b1;
        end else if (done) begin
            stub_on = 1'b0;
        end else if (stub_on) begin
            stub_cnt++;
        end
        core_w_data_en = stub_on && stub_cnt >= wr_first && stub_cnt < wr_first + wr_pulses;
    end

    // Monitor
    logic [26:0] cfg_now, run_cfg, exp_cfg;
    done_t       exp_done;
    int          cyc = 0;
    int          start_cyc = 0;
    int          last_start = -1;
    bit          spacing_chk = 1'b0;
    assign cfg_now = {core_mode, core_add_or_sub, core_r_start_offset_A,
                      core_r_start_offset_B, core_w_data_addr_offset};

    always @(negedge clk) begin
        cyc++;
        if (core_start) begin
            if (sq.size() == 0) check("unexpected_start", 1, 0);
            else begin
                exp_cfg = sq.pop_front();
                check("start_cfg", cfg_now, exp_cfg);
            end
            if (spacing_chk && last_start >= 0) check("issue_spacing", cyc - last_start, 237);
            last_start = cyc;
            start_cyc  = cyc;
            run_cfg    = cfg_now;
        end
        if (done) begin
            if (dq.size() == 0) check("unexpected_done", 1, 0);
            else begin
                exp_done = dq.pop_front();
                check("done_tag", done_tag, exp_done.tag);
                check("done_wr_count", done_wr_count, exp_done.wr);
                check("done_latency", cyc - start_cyc, exp_done.lat + 1);
                check("cfg_stable", cfg_now, run_cfg);
            end
        end
    end

    // exp_run: 0 = stays queued/discarded, 1 = issued but never completes, 2 = issued and completes
    task automatic push_cmd(input logic [3:0] tag, input logic [1:0] mode, input logic aos,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] w,
                            input bit exp_acc, input int exp_run, input int wr_exp,
                            input bit hold);
        cmd_valid      = 1'b1;
        cmd_tag        = tag;
        cmd_mode       = mode;
        cmd_add_or_sub = aos;
        cmd_off_a      = a;
        cmd_off_b      = b;
        cmd_off_w      = w;
        #1;
        check("cmd_ready", cmd_ready, exp_acc);
        if (exp_acc && exp_run >= 1) sq.push_back({mode, aos, a, b, w});
        if (exp_acc && exp_run == 2) dq.push_back('{tag, 8'(wr_exp), lat_of(mode)});
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(busy == 1'b0 && fifo_level == 3'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n < budget, 1);
    endtask

    task automatic wait_not_busy(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_timeout", n < budget, 1);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_tag = '0; cmd_mode = '0; cmd_add_or_sub = 1'b0;
        cmd_off_a = '0; cmd_off_b = '0; cmd_off_w = '0; flush = 1'b0;

        #3;
        check("rst_core_start", core_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_level", fifo_level, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cfg", cfg_now, 0);
        tick(2);
        rst = 1'b1;
        tick(1);

        // Single ADDSUB, latency of start after push
        push_cmd(4'd5, 2'd3, 1'b1, 8'h10, 8'h20, 8'h40, 1, 2, 0, 0);
        check("level_after_push", fifo_level, 1);
        check("start_not_yet", core_start, 0);
        tick(1);
        check("start_latency", core_start, 1);
        wait_idle(400);

        // Write counting: 31 strobes, then strobe high through the whole RUN
        wr_first = 10; wr_pulses = 31;
        push_cmd(4'd1, 2'd0, 1'b0, 8'h01, 8'h02, 8'h03, 1, 2, 31, 0);
        wait_idle(400);
        wr_first = 1; wr_pulses = 1000;
        push_cmd(4'd2, 2'd1, 1'b0, 8'h11, 8'h22, 8'h33, 1, 2, LAT_NTT, 0);
        wait_idle(400);
        wr_pulses = 0;

        // Backpressure: 5 back-to-back pushes during RUN, only 4 fit
        spacing_chk = 1'b1;
        last_start  = -1;
        push_cmd(4'd3, 2'd0, 1'b0, 8'h30, 8'h31, 8'h32, 1, 2, 0, 0);
        tick(5);
        for (int i = 0; i < 5; i++) begin
            push_cmd(4'(4 + i), 2'd0, i[0], 8'(i), 8'(2 * i), 8'(3 * i + 1),
                     i < 4, (i < 4) ? 2 : 0, 0, 1);
        end
        cmd_valid = 1'b0;
        check("bp_level", fifo_level, 4);
        check("bp_ready", cmd_ready, 0);
        wait_idle(2000);
        spacing_chk = 1'b0;

        // Flush during RUN: first MULT completes, queued ones vanish, push is refused
        for (int i = 0; i < 3; i++) begin
            push_cmd(4'(9 + i), 2'd2, 1'b0, 8'(16 * i), 8'(16 * i + 1), 8'(16 * i + 2),
                     1, (i == 0) ? 2 : 0, 0, 1);
        end
        cmd_valid = 1'b0;
        tick(10);
        flush = 1'b1;
        push_cmd(4'd12, 2'd2, 1'b0, 8'hee, 8'hee, 8'hee, 0, 0, 0, 0);
        flush = 1'b0;
        check("flush_level", fifo_level, 0);
        check("flush_busy", busy, 1);
        wait_idle(400);
        tick(20);

        // Flush in the same cycle as an IDLE pop suppresses the issue
        push_cmd(4'd8, 2'd3, 1'b0, 8'h80, 8'h81, 8'h82, 1, 0, 0, 0);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("flush_pop_level", fifo_level, 0);
        check("flush_pop_busy", busy, 0);
        tick(5);

        // Simultaneous push/pop at level 2, then a full FIFO refusing a push during a pop
        push_cmd(4'd13, 2'd3, 1'b1, 8'h13, 8'h14, 8'h15, 1, 2, 0, 0);
        tick(5);
        push_cmd(4'd14, 2'd3, 1'b0, 8'h41, 8'h42, 8'h43, 1, 2, 0, 1);
        push_cmd(4'd15, 2'd3, 1'b1, 8'h51, 8'h52, 8'h53, 1, 2, 0, 0);
        check("sim_level_pre", fifo_level, 2);
        wait_not_busy(200);
        push_cmd(4'd0, 2'd3, 1'b0, 8'h61, 8'h62, 8'h63, 1, 2, 0, 0);
        check("sim_level_pushpop", fifo_level, 2);
        push_cmd(4'd1, 2'd3, 1'b1, 8'h71, 8'h72, 8'h73, 1, 2, 0, 1);
        push_cmd(4'd2, 2'd3, 1'b0, 8'h81, 8'h82, 8'h83, 1, 2, 0, 0);
        check("sim_level_full", fifo_level, 4);
        wait_not_busy(200);
        push_cmd(4'd3, 2'd3, 1'b1, 8'h91, 8'h92, 8'h93, 0, 0, 0, 0);
        check("sim_level_after_reject", fifo_level, 3);
        wait_idle(1000);

        // Reset mid-RUN: operation abandoned, queue cleared, no done
        push_cmd(4'd6, 2'd0, 1'b0, 8'ha1, 8'ha2, 8'ha3, 1, 1, 0, 0);
        tick(52);
        push_cmd(4'd7, 2'd0, 1'b0, 8'hb1, 8'hb2, 8'hb3, 1, 0, 0, 0);
        check("rr_level_pre", fifo_level, 1);
        rst = 1'b0;
        #1;
        check("rr_core_start", core_start, 0);
        check("rr_busy", busy, 0);
        check("rr_done", done, 0);
        check("rr_level", fifo_level, 0);
        check("rr_cfg", cfg_now, 0);
        tick(1);
        rst = 1'b1;
        #1;
        check("rr_cmd_ready", cmd_ready, 1);
        tick(300);

        check("start_queue_empty", sq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
